// File: rtl/deskewer.sv
// Re-aligns a diagonally skewed mesh output stream into whole rows.
// It also counts the emitted valid rows and pulses done_o at the end of each tile.
module deskewer #(
    parameter int MESH_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_ROWS   = 4,
    localparam int CNT_W     = $clog2(NUM_ROWS + 1)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 clear_i,
    input  logic                                 pump_i,
    input  logic                                 valid_i,
    input  logic [MESH_WIDTH-1:0][DATA_WIDTH-1:0] data_i,
    output logic [MESH_WIDTH-1:0][DATA_WIDTH-1:0] data_o,
    output logic                                 valid_o,
    output logic [CNT_W-1:0]                     row_cnt_o,
    output logic                                 done_o
);

    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(NUM_ROWS - 1);

    logic             row_vld;
    logic [CNT_W-1:0] row_cnt_q;
    logic             done_q;

    // Lane i trails lane 0 by i pumps, so it waits MESH_WIDTH-1-i pumps here.
    for (genvar i = 0; i < MESH_WIDTH - 1; i++) begin : g_lane
        localparam int D = MESH_WIDTH - 1 - i;
        logic [D-1:0][DATA_WIDTH-1:0] dly_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                dly_q <= '0;
            end else if (clear_i) begin
                dly_q <= '0;
            end else if (pump_i) begin
                dly_q[0] <= data_i[i];
                for (int k = 1; k < D; k++) begin
                    dly_q[k] <= dly_q[k-1];
                end
            end
        end

        assign data_o[i] = dly_q[D-1];
    end

    assign data_o[MESH_WIDTH-1] = data_i[MESH_WIDTH-1];

    if (MESH_WIDTH > 1) begin : g_vld
        logic [MESH_WIDTH-2:0] vld_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                vld_q <= '0;
            end else if (clear_i) begin
                vld_q <= '0;
            end else if (pump_i) begin
                vld_q[0] <= valid_i;
                for (int k = 1; k < MESH_WIDTH - 1; k++) begin
                    vld_q[k] <= vld_q[k-1];
                end
            end
        end

        assign row_vld = vld_q[MESH_WIDTH-2];
    end else begin : g_no_vld
        assign row_vld = valid_i;
    end

    assign valid_o = row_vld & pump_i & ~clear_i;

    // Wrap and done share one edge, so back-to-back tiles never stretch done_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_cnt_q <= '0;
            done_q    <= 1'b0;
        end else if (clear_i) begin
            row_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (valid_o) begin
                if (row_cnt_q == LAST_ROW) begin
                    row_cnt_q <= '0;
                    done_q    <= 1'b1;
                end else begin
                    row_cnt_q <= row_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign row_cnt_o = row_cnt_q;
    assign done_o    = done_q;

endmodule
